// File: rtl/alv_vhdl_div_pkg.sv
// Shared definitions for the iterative signed divider: FSM encoding,
// counter sizing and the constant results used for special operands.
package alv_vhdl_div_pkg;

    localparam int DIV_W = 32;
    localparam int CNT_W = $clog2(DIV_W);
    localparam logic [DIV_W-1:0] DIV0_Q = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    // Operand classes whose result is forced at FIX instead of taken from the datapath
    typedef enum logic [1:0] {
        SPC_NONE = 2'd0,
        SPC_DIV0 = 2'd1,
        SPC_OVF  = 2'd2,
        SPC_ZERO = 2'd3
    } div_spc_e;

endpackage

// File: rtl/alv_vhdl_udiv_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference if it fits.
module alv_vhdl_udiv_step
    import alv_vhdl_div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] prem_i,
    input  logic         bit_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] prem_o,
    output logic         q_o
);

    logic [W:0] shifted;

    assign shifted = {prem_i, bit_i};
    assign q_o     = (shifted >= {1'b0, dvs_i});
    // When the subtraction succeeds the result is below the divisor, so W bits suffice
    assign prem_o  = q_o ? (shifted[W-1:0] - dvs_i) : shifted[W-1:0];

endmodule

// File: rtl/alv_vhdl_sdiv_32s_32s_32_seq.sv
// Iterative signed divider with start/done handshake: magnitudes are divided
// one quotient bit per enabled cycle, then signs and special cases are applied.
module alv_vhdl_sdiv_32s_32s_32_seq
    import alv_vhdl_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIV_W,
    parameter int din1_WIDTH = DIV_W,
    parameter int dout_WIDTH = DIV_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [dout_WIDTH-1:0] rem
);

    localparam int W = din0_WIDTH;

    if (din1_WIDTH != din0_WIDTH || dout_WIDTH != din0_WIDTH || din0_WIDTH != DIV_W || ID < 0) begin : g_bad_cfg
        $error("alv_vhdl_sdiv_32s_32s_32_seq: all widths must equal DIV_W");
    end

    div_state_e       state_q;
    div_spc_e         spc_q;
    div_spc_e         spc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     dvd_q;
    logic [W-1:0]     dvs_q;
    logic [W-1:0]     prem_q;
    logic [W-1:0]     dout_q;
    logic [W-1:0]     rem_q;
    logic             sign0_q;
    logic             sign1_q;
    logic             done_q;

    logic [W:0]       abs0_d;
    logic [W:0]       abs1_d;
    logic [W-1:0]     step_prem;
    logic             step_q;
    logic [W-1:0]     quot_d;
    logic [W-1:0]     rem_d;

    // Magnitudes in W+1 bits so that |MIN| is representable
    always_comb begin
        abs0_d = din0[W-1] ? -{din0[W-1], din0} : {din0[W-1], din0};
        abs1_d = din1[W-1] ? -{din1[W-1], din1} : {din1[W-1], din1};
        if (abs1_d == '0)
            spc_d = SPC_DIV0;
        else if (din0 == {1'b1, {(W-1){1'b0}}} && din1 == '1)
            spc_d = SPC_OVF;
        else if (abs0_d == '0)
            spc_d = SPC_ZERO;
        else
            spc_d = SPC_NONE;
    end

    alv_vhdl_udiv_step #(
        .W (W)
    ) u_step (
        .prem_i (prem_q),
        .bit_i  (dvd_q[W-1]),
        .dvs_i  (dvs_q),
        .prem_o (step_prem),
        .q_o    (step_q)
    );

    // Quotient takes the XOR of the signs, remainder follows the dividend
    always_comb begin
        quot_d = (sign0_q ^ sign1_q) ? -dvd_q : dvd_q;
        rem_d  = sign0_q ? -prem_q : prem_q;
        case (spc_q)
            SPC_DIV0: quot_d = DIV0_Q;
            SPC_OVF: begin
                quot_d = {1'b1, {(W-1){1'b0}}};
                rem_d  = '0;
            end
            SPC_ZERO: begin
                quot_d = '0;
                rem_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            spc_q   <= SPC_NONE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            sign0_q <= 1'b0;
            sign1_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (ce) begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dvd_q   <= abs0_d[W-1:0];
                        dvs_q   <= abs1_d[W-1:0];
                        sign0_q <= din0[W-1];
                        sign1_q <= din1[W-1];
                        spc_q   <= spc_d;
                        prem_q  <= '0;
                        cnt_q   <= CNT_W'(W-1);
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Dividend bits leave at the top while quotient bits enter at the bottom
                    prem_q <= step_prem;
                    dvd_q  <= {dvd_q[W-2:0], step_q};
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0)
                        state_q <= ST_FIX;
                end
                ST_FIX: begin
                    dout_q  <= quot_d;
                    rem_q   <= rem_d;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign done  = done_q;
    assign dout  = dout_q;
    assign rem   = rem_q;

endmodule

// File: tb/tb_alv_vhdl_sdiv_32s_32s_32_seq.sv
// Scoreboard bench for the iterative signed divider: expected results are
// queued at accept time and compared when done pulses.
module tb_alv_vhdl_sdiv_32s_32s_32_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        start;
    logic [31:0] din0;
    logic [31:0] din1;
    logic        ready;
    logic        done;
    logic [31:0] dout;
    logic [31:0] rem;

    always #5 clk = ~clk;

    alv_vhdl_sdiv_32s_32s_32_seq #(
        .ID         (1),
        .din0_WIDTH (32),
        .din1_WIDTH (32),
        .dout_WIDTH (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (start),
        .din0  (din0),
        .din1  (din1),
        .ready (ready),
        .done  (done),
        .dout  (dout),
        .rem   (rem)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          e0;
    } txn_t;

    txn_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   ecnt  = 0;
    int   cyc   = 0;
    logic done_seen = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ce)
            ecnt <= ecnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (sb == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (a == 32'h8000_0000 && sb == -1) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    // Each distinct done pulse retires one scoreboard entry
    always @(negedge clk) begin
        txn_t t;
        if (done && !done_seen) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_done", 32'd1, 32'd0);
            end else begin
                t = sb_q.pop_front();
                $display("txn %0d / %0d -> q=%0d r=%0d", $signed(t.a), $signed(t.b), $signed(dout), $signed(rem));
                check_val("quot", dout, t.q);
                check_val("rem", rem, t.r);
                check_val("latency", 32'(ecnt - t.e0), 32'd33);
            end
        end
        done_seen <= done;
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit push);
        txn_t t;
        int   budget;
        budget = 0;
        while (!ready && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!ready)
            check_val("ready_timeout", 32'd0, 32'd1);
        start = 1'b1;
        din0  = a;
        din1  = b;
        @(posedge clk); #1;
        if (push) begin
            t.a  = a;
            t.b  = b;
            ref_div(a, b, t.q, t.r);
            t.e0 = ecnt;
            sb_q.push_back(t);
        end
        start = 1'b0;
        din0  = $urandom;
        din1  = $urandom;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb_q.size() != 0 && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        if (sb_q.size() != 0) begin
            check_val("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while (!done && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!done)
            check_val("done_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h8000_0000;
            1:       v = 32'h7FFF_FFFF;
            2:       v = 32'd1;
            3:       v = 32'hFFFF_FFFF;
            4:       v = 32'd0;
            5:       v = 32'($urandom_range(0, 200)) - 32'd100;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        reset = 1'b1;
        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", 32'(ready), 32'd1);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_dout", dout, 32'd0);
        check_val("rst_rem", rem, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Sign combinations and special operands
        do_op(32'd100, 32'd7, 1'b1);
        do_op(-32'd100, 32'd7, 1'b1);
        do_op(32'd100, -32'd7, 1'b1);
        do_op(-32'd100, -32'd7, 1'b1);
        do_op(32'd1234, 32'd0, 1'b1);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_op(32'd0, 32'd55, 1'b1);
        drain();

        // Clock-enable stall during CALC, then a frozen done
        do_op(32'd1000, 32'd3, 1'b1);
        c0 = cyc;
        repeat (4) begin @(posedge clk); #1; end
        ce = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        ce = 1'b1;
        wait_done();
        check_val("stall_wall_lat", 32'(cyc - c0), 32'd40);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("done_held", 32'(done), 32'd1);
            check_val("dout_held", dout, 32'd333);
        end
        ce = 1'b1;
        @(posedge clk); #1;
        check_val("done_clear", 32'(done), 32'd0);
        drain();

        // Start while busy is ignored; start in the done cycle is accepted
        do_op(32'd200, 32'd9, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        check_val("busy_ready", 32'(ready), 32'd0);
        start = 1'b1;
        din0  = 32'd5;
        din1  = 32'd5;
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b0;
        wait_done();
        check_val("ready_at_done", 32'(ready), 32'd1);
        do_op(-32'd77777, 32'd123, 1'b1);
        drain();

        // Reset in the middle of a calculation
        do_op(32'd777, 32'd3, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("abort_ready", 32'(ready), 32'd1);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_dout", dout, 32'd0);
        check_val("abort_rem", rem, 32'd0);
        repeat (40) begin @(posedge clk); #1; end
        do_op(32'd50, 32'd5, 1'b1);
        drain();

        // Random stream, issued back to back
        for (int i = 0; i < 1000; i++)
            do_op(pick_operand(), pick_operand(), 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
